// File: rtl/seq_det_event_monitor.sv
// seq_det_event_monitor: turns detector hits into counted event pulses with gap, burst and timeout tracking
module seq_det_event_monitor #(
  parameter int CNT_W     = 16,
  parameter int GAP_W     = 12,
  parameter int TIMEOUT   = 1000,
  parameter int BURST_N   = 4,
  parameter int BURST_WIN = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             det,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_count,
  output logic [GAP_W-1:0] gap_last,
  output logic             gap_valid,
  output logic             burst,
  output logic             timeout,
  output logic [1:0]       state
);
  localparam int SUM_W = $clog2(BURST_WIN + 1);
  typedef enum logic [1:0] {IDLE, ARMED, TRACK, ALARM} st_t;
  st_t st, st_n;
  logic det_q, evt, acc, gv_n, to_n;
  logic [GAP_W-1:0] timer, timer_n, gap_n;
  logic [BURST_WIN-1:0] hist;
  logic [SUM_W-1:0] sum, sum_n;
  assign evt = det & ~det_q;
  assign acc = evt & (st != IDLE) & ~clr;
  assign sum_n = sum + SUM_W'(acc) - SUM_W'(hist[BURST_WIN-1]);
  assign state = st;
  always_comb begin
    st_n = st;
    timer_n = timer;
    gap_n = gap_last;
    gv_n = 1'b0;
    to_n = timeout;
    if (clr) begin
      st_n = en ? ARMED : IDLE;
      timer_n = '0;
      gap_n = '0;
      to_n = 1'b0;
    end else if (!en) begin
      st_n = IDLE;
      timer_n = '0;
    end else begin
      case (st)
        IDLE: st_n = ARMED;
        ARMED: if (evt) begin
          st_n = TRACK;
          timer_n = GAP_W'(1);
        end
        TRACK: if (evt) begin
          gap_n = timer;
          gv_n = 1'b1;
          timer_n = GAP_W'(1);
        end else if (timer == GAP_W'(TIMEOUT)) begin
          st_n = ALARM;
          to_n = 1'b1;
        end else begin
          timer_n = &timer ? timer : timer + GAP_W'(1);
        end
        ALARM: if (evt) begin
          st_n = TRACK;
          to_n = 1'b0;
          timer_n = GAP_W'(1);
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st <= IDLE;
      det_q <= 1'b0;
      timer <= '0;
      gap_last <= '0;
      gap_valid <= 1'b0;
      timeout <= 1'b0;
      evt_pulse <= 1'b0;
      evt_count <= '0;
      hist <= '0;
      sum <= '0;
      burst <= 1'b0;
    end else begin
      st <= st_n;
      det_q <= det;
      timer <= timer_n;
      gap_last <= gap_n;
      gap_valid <= gv_n;
      timeout <= to_n;
      evt_pulse <= acc;
      evt_count <= clr ? '0 : (acc && !(&evt_count)) ? evt_count + CNT_W'(1) : evt_count;
      hist <= clr ? '0 : (hist << 1) | BURST_WIN'(acc);
      sum <= clr ? '0 : sum_n;
      burst <= clr ? 1'b0 : (sum_n >= SUM_W'(BURST_N));
    end
  end
endmodule

// File: tb/tb_seq_det_event_monitor.sv
// tb_seq_det_event_monitor: table-driven and scoreboard checks of seq_det_event_monitor
module tb_seq_det_event_monitor;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, clr = 1'b0, det = 1'b0;
  logic evt_pulse, gap_valid, burst, timeout;
  logic [3:0] evt_count;
  logic [11:0] gap_last;
  logic [1:0] state;
  logic [21:0] act;
  int checks = 0, errors = 0;
  typedef struct {
    logic en, clr, det;
    logic [21:0] o;
  } vec_t;
  vec_t tbl[$];
  logic [21:0] exp_q[$];
  logic bexp_q[$];
  int ev[$];
  seq_det_event_monitor #(.CNT_W(4), .GAP_W(12), .TIMEOUT(1000), .BURST_N(4), .BURST_WIN(32)) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .det(det),
    .evt_pulse(evt_pulse), .evt_count(evt_count), .gap_last(gap_last), .gap_valid(gap_valid),
    .burst(burst), .timeout(timeout), .state(state)
  );
  assign act = {evt_pulse, evt_count, gap_valid, gap_last, state, burst, timeout};
  always #5 clk = ~clk;
  function automatic logic [21:0] pk(input int p, n, gv, gp, s, b, t);
    return {1'(p), 4'(n), 1'(gv), 12'(gp), 2'(s), 1'(b), 1'(t)};
  endfunction
  task automatic row(input int e, c, d, p, n, gv, gp, s, b, t);
    vec_t v;
    v.en = 1'(e);
    v.clr = 1'(c);
    v.det = 1'(d);
    v.o = pk(p, n, gv, gp, s, b, t);
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic e, c, d);
    en = e;
    clr = c;
    det = d;
  endtask
  initial begin
    int n;
    row(1,0,0, 0,0,0,0,1,0,0);
    row(1,0,1, 1,1,0,0,2,0,0);
    row(1,0,0, 0,1,0,0,2,0,0);
    row(1,0,0, 0,1,0,0,2,0,0);
    row(1,0,1, 1,2,1,3,2,0,0);
    row(1,0,1, 0,2,0,3,2,0,0);
    row(1,0,1, 0,2,0,3,2,0,0);
    row(1,0,0, 0,2,0,3,2,0,0);
    row(1,0,1, 1,3,1,4,2,0,0);
    row(1,0,0, 0,3,0,4,2,0,0);
    row(1,0,1, 1,4,1,2,2,1,0);
    row(1,0,0, 0,4,0,2,2,1,0);
    row(0,0,0, 0,4,0,2,0,1,0);
    row(0,0,1, 0,4,0,2,0,1,0);
    row(0,0,0, 0,4,0,2,0,1,0);
    row(1,0,1, 0,4,0,2,1,1,0);
    row(1,0,0, 0,4,0,2,1,1,0);
    row(1,0,1, 1,5,0,2,2,1,0);
    row(1,1,0, 0,0,0,0,1,0,0);
    row(1,0,1, 1,1,0,0,2,0,0);
    row(1,0,0, 0,1,0,0,2,0,0);
    row(1,1,1, 0,0,0,0,1,0,0);
    row(1,0,1, 0,0,0,0,1,0,0);
    row(0,1,0, 0,0,0,0,0,0,0);
    repeat (2) tick;
    chk("reset_outputs", act, 0);
    rstn = 1'b1;
    tick;
    chk("idle_en_low", act, 0);
    foreach (tbl[i]) begin
      drv(tbl[i].en, tbl[i].clr, tbl[i].det);
      exp_q.push_back(tbl[i].o);
      tick;
      chk($sformatf("row%0d", i), act, exp_q.pop_front());
    end
    drv(1, 1, 0);
    tick;
    for (int i = 0; i < 45; i++) begin
      int c;
      logic d;
      d = (i < 12) && (i % 3 == 0);
      drv(1, 0, d);
      if (d) ev.push_back(i);
      c = 0;
      foreach (ev[k]) if (ev[k] > i - 32) c++;
      bexp_q.push_back(c >= 4);
      tick;
      chk($sformatf("burst_c%0d", i), burst, bexp_q.pop_front());
    end
    drv(1, 1, 0);
    tick;
    drv(1, 0, 1);
    tick;
    chk("to_first_pulse", {evt_pulse, state}, {1'b1, 2'd2});
    drv(1, 0, 0);
    n = 0;
    while (state != 2'd3 && n < 1100) begin
      tick;
      n++;
    end
    chk("timeout_latency", n, 1000);
    chk("timeout_flag", timeout, 1);
    drv(1, 0, 1);
    tick;
    chk("alarm_exit", {state, timeout, gap_valid, gap_last, evt_count}, {2'd2, 1'b0, 1'b0, 12'd0, 4'd2});
    drv(1, 1, 0);
    tick;
    for (int k = 1; k <= 20; k++) begin
      drv(1, 0, 1);
      tick;
      chk($sformatf("sat_%0d", k), evt_count, (k > 15) ? 15 : k);
      drv(1, 0, 0);
      tick;
    end
    drv(1, 1, 1);
    tick;
    chk("clr_vs_evt", {evt_count, evt_pulse, state}, {4'd0, 1'b0, 2'd1});
    drv(1, 0, 0);
    tick;
    drv(1, 0, 1);
    tick;
    drv(1, 0, 0);
    tick;
    chk("pre_async_rst", {state, evt_count}, {2'd2, 4'd1});
    #3 rstn = 1'b0;
    #1 chk("async_rst", act, 0);
    tick;
    rstn = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
